// File: rtl/filter_cfg_arbiter.sv
// rtl/filter_cfg_arbiter.sv - two-requester arbiter for a serial filter configuration shift chain
module filter_cfg_arbiter #(
    parameter int SREG_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [SREG_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [SREG_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [SREG_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [SREG_W-1:0] req1_rdata,
    output logic              sde_out,
    output logic              sd_out,
    input  logic              sd_in,
    output logic              ul_out,
    output logic              dl_out,
    output logic              busy_out
);

    localparam int CNT_W = $clog2(SREG_W + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DL    = 3'd1,
        S_SHIFT = 3'd2,
        S_UL    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [SREG_W-1:0]  sreg;
    logic [SREG_W-1:0]  rdata0_q;
    logic [SREG_W-1:0]  rdata1_q;
    logic               wr_q;
    logic               gnt_q;
    logic               last_gnt;
    logic               sde_q;
    logic               dl_q;
    logic               ul_q;
    logic               done_q;
    logic               busy_q;
    logic               gnt_sel;
    logic               sel_write;
    logic [SREG_W-1:0]  sel_wdata;
    logic               accept;
    logic               shift_last;
    logic [SREG_W-1:0]  shift_next;

    // Round-robin pick: on a tie the requester not granted last wins
    assign gnt_sel    = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
    assign sel_write  = gnt_sel ? req1_write : req0_write;
    assign sel_wdata  = gnt_sel ? req1_wdata : req0_wdata;
    // Ready is masked by reset so every output reads 0 while rst_n is low
    assign req0_ready = rst_n && (state == S_IDLE) && req0_valid && !gnt_sel;
    assign req1_ready = rst_n && (state == S_IDLE) && req1_valid && gnt_sel;
    assign accept     = req0_ready || req1_ready;
    assign shift_last = (state == S_SHIFT) && (cnt == CNT_W'(1));
    // Outgoing bits leave from the MSB; incoming bits enter at the LSB
    assign shift_next = {sreg[SREG_W-2:0], (wr_q ? 1'b0 : sd_in)};

    assign sde_out    = sde_q;
    assign sd_out     = sde_q && wr_q && sreg[SREG_W-1];
    assign dl_out     = dl_q;
    assign ul_out     = ul_q;
    assign busy_out   = busy_q;
    assign req0_done  = done_q && !gnt_q;
    assign req1_done  = done_q && gnt_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: write skips DL, read skips UL
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = sel_write ? S_SHIFT : S_DL;
            S_DL:    state_nxt = S_SHIFT;
            S_SHIFT: if (shift_last) state_nxt = wr_q ? S_UL : S_DONE;
            S_UL:    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they are glitch-free and exclusive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sde_q  <= 1'b0;
            dl_q   <= 1'b0;
            ul_q   <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            sde_q  <= (state_nxt == S_SHIFT);
            dl_q   <= (state_nxt == S_DL);
            ul_q   <= (state_nxt == S_UL);
            done_q <= (state_nxt == S_DONE);
            busy_q <= (state_nxt != S_IDLE);
        end
    end

    // Latch the accepted request and advance the grant pointer only on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= 1'b0;
            gnt_q    <= 1'b0;
            last_gnt <= 1'b1;
        end else if (accept) begin
            wr_q     <= sel_write;
            gnt_q    <= gnt_sel;
            last_gnt <= gnt_sel;
        end
    end

    // Shift chain and bit counter; a read loads the counter on its DL cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sreg <= '0;
        end else begin
            if (accept) begin
                sreg <= sel_wdata;
                if (sel_write) cnt <= CNT_W'(SREG_W);
            end else if (state == S_DL) begin
                cnt <= CNT_W'(SREG_W);
            end else if (state == S_SHIFT) begin
                cnt  <= cnt - CNT_W'(1);
                sreg <= shift_next;
            end
        end
    end

    // Read data commits only once the final bit is captured, into the granted slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (shift_last && !wr_q) begin
            if (gnt_q) rdata1_q <= shift_next;
            else       rdata0_q <= shift_next;
        end
    end

endmodule

// File: tb/tb_filter_cfg_arbiter.sv
// tb/tb_filter_cfg_arbiter.sv - randomized self-checking bench for filter_cfg_arbiter
module tb_filter_cfg_arbiter;

    localparam int W = 32;
    localparam int SPAN = W + 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_write, req0_ready, req0_done;
    logic [W-1:0] req0_wdata, req0_rdata;
    logic         req1_valid, req1_write, req1_ready, req1_done;
    logic [W-1:0] req1_wdata, req1_rdata;
    logic         sde_out, sd_out, sd_in, ul_out, dl_out, busy_out;

    always #5 clk = ~clk;

    filter_cfg_arbiter #(.SREG_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_done(req0_done), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_done(req1_done), .req1_rdata(req1_rdata),
        .sde_out(sde_out), .sd_out(sd_out), .sd_in(sd_in),
        .ul_out(ul_out), .dl_out(dl_out), .busy_out(busy_out)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: one transaction described by its start cycle and kind
    bit           act;
    int           t0;
    bit           mwr;
    bit           mg;
    logic [W-1:0] mwd;
    logic [W-1:0] rd_acc;
    bit           lg;
    logic [W-1:0] rexp [2];

    bit           hold_valid;
    bit           use_pat;
    logic [W-1:0] sd_pat;
    int           acc_cyc [$];
    bit           acc_gnt [$];
    int           ul_seen;
    bit           clr0, clr1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: inputs already driven at the falling edge
    task automatic step();
        int k;
        bit in_ws, in_rs, eg, er0, er1;
        if (!rst_n) begin
            act = 0; lg = 1; rexp[0] = '0; rexp[1] = '0;
        end
        if (act && (cyc - t0) >= SPAN) act = 0;
        k = act ? (cyc - t0) : 0;
        in_ws = act && mwr && k >= 1 && k <= W;
        in_rs = act && !mwr && k >= 2 && k <= W + 1;
        if (use_pat && in_rs) sd_in = sd_pat[W + 1 - k];
        else                  sd_in = 1'($urandom);
        #1;
        eg  = (req0_valid && req1_valid) ? !lg : req1_valid;
        er0 = rst_n && !act && req0_valid && !eg;
        er1 = rst_n && !act && req1_valid && eg;
        chk("req0_ready", req0_ready, er0);
        chk("req1_ready", req1_ready, er1);
        chk("sde_out", sde_out, in_ws || in_rs);
        chk("sd_out", sd_out, in_ws ? mwd[W - k] : 1'b0);
        chk("dl_out", dl_out, act && !mwr && k == 1);
        chk("ul_out", ul_out, act && mwr && k == W + 1);
        chk("busy_out", busy_out, act);
        chk("req0_done", req0_done, act && k == W + 2 && !mg);
        chk("req1_done", req1_done, act && k == W + 2 && mg);
        chk("req0_rdata", req0_rdata, rexp[0]);
        chk("req1_rdata", req1_rdata, rexp[1]);
        if (ul_out === 1'b1) ul_seen++;
        clr0 = 0; clr1 = 0;
        @(posedge clk);
        if (rst_n) begin
            if (in_rs) begin
                rd_acc = {rd_acc[W-2:0], sd_in};
                if (k == W + 1) rexp[mg] = rd_acc;
            end
            if (er0 || er1) begin
                act = 1; t0 = cyc; mg = er1; lg = er1;
                mwr = er1 ? req1_write : req0_write;
                mwd = er1 ? req1_wdata : req0_wdata;
                acc_cyc.push_back(cyc);
                acc_gnt.push_back(er1);
                if (!hold_valid) begin
                    clr0 = er0; clr1 = er1;
                end
            end
        end
        cyc++;
        @(negedge clk);
        if (clr0) req0_valid = 0;
        if (clr1) req1_valid = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_drive();
        if (!req0_valid && $urandom_range(3) == 0) begin
            req0_valid = 1; req0_write = 1'($urandom); req0_wdata = W'($urandom);
        end else if (req0_valid && $urandom_range(40) == 0) begin
            req0_valid = 0;
        end
        if (!req1_valid && $urandom_range(3) == 0) begin
            req1_valid = 1; req1_write = 1'($urandom); req1_wdata = W'($urandom);
        end else if (req1_valid && $urandom_range(40) == 0) begin
            req1_valid = 0;
        end
    endtask

    initial begin
        int n, ul_before;
        rst_n = 0; sd_in = 0;
        req0_valid = 0; req0_write = 0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_wdata = '0;
        hold_valid = 0; use_pat = 0; sd_pat = '0; ul_seen = 0;
        act = 0; lg = 1; rd_acc = '0; mwd = '0; mwr = 0; mg = 0; t0 = 0;
        rexp[0] = '0; rexp[1] = '0;
        @(negedge clk);
        req0_valid = 1; req1_valid = 1;
        steps(2);
        req0_valid = 0; req1_valid = 0;
        rst_n = 1;

        // Single write from requester 0, accepted in the first cycle after reset
        req0_valid = 1; req0_write = 1; req0_wdata = 32'hA5A5_00FF;
        steps(SPAN + 3);
        chk("wr_ul_count", ul_seen, 1);
        chk("wr_accept_cycle", acc_cyc.size() > 0 ? acc_cyc[0] : -1, 2);

        // Read from requester 1 with the filter returning a known word
        use_pat = 1; sd_pat = 32'h1234_5678;
        req1_valid = 1; req1_write = 0; req1_wdata = W'($urandom);
        steps(SPAN + 3);
        use_pat = 0;
        chk("rd_rdata1", req1_rdata, 32'h1234_5678);
        chk("rd_rdata0_held", req0_rdata, 32'h0);

        // Tie held: grants alternate, then a lone requester runs back-to-back
        acc_cyc.delete(); acc_gnt.delete();
        hold_valid = 1;
        req0_valid = 1; req0_write = 1; req0_wdata = W'($urandom);
        req1_valid = 1; req1_write = 0;
        steps(4 * SPAN);
        req1_valid = 0;
        steps(2 * SPAN);
        req0_valid = 0; hold_valid = 0;
        steps(SPAN);
        n = acc_cyc.size();
        chk("tie_accepts", n, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < n) chk("tie_grant", acc_gnt[i], (i < 4) ? (i % 2) : 0);
            if (i > 0 && i < n) chk("accept_spacing", acc_cyc[i] - acc_cyc[i-1], SPAN);
        end

        // Busy hold: requester 1 arrives mid-shift and wins the first idle cycle
        acc_cyc.delete(); acc_gnt.delete();
        req0_valid = 1; req0_write = 1; req0_wdata = W'($urandom);
        steps(10);
        req1_valid = 1; req1_write = 1; req1_wdata = W'($urandom);
        steps(2 * SPAN + 2);
        n = acc_cyc.size();
        chk("busy_accepts", n, 2);
        if (n >= 2) begin
            chk("busy_grant", acc_gnt[1], 1);
            chk("busy_spacing", acc_cyc[1] - acc_cyc[0], SPAN);
        end

        // Reset during write shift bit 10 aborts; next tie goes to requester 0
        acc_cyc.delete(); acc_gnt.delete();
        req0_valid = 1; req0_write = 1; req0_wdata = W'($urandom);
        steps(11);
        ul_before = ul_seen;
        rst_n = 0;
        steps(1);
        rst_n = 1;
        steps(SPAN);
        chk("abort_no_ul", ul_seen, ul_before);
        acc_cyc.delete(); acc_gnt.delete();
        req0_valid = 1; req0_write = 0; req1_valid = 1; req1_write = 0;
        steps(1);
        chk("abort_tie_grant", acc_gnt.size() > 0 ? acc_gnt[0] : 1'bx, 0);
        steps(SPAN);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rand_drive();
            if ($urandom_range(700) == 0) rst_n = 0;
            step();
            rst_n = 1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
